duck_round_ctrl: RTL

Game-flow sequencer for the duck sprite datapath. It runs one round of DUCKS_PER_ROUND ducks. For each duck it sequences spawn, flight, shot, fall and escape phases. It also owns the shot, hit and score counters. It sits between the input/hit-detect logic (trigger, hit) and the duck motion and sprite module, which it drives with enable/freeze/fall/fly-away controls.

---
 rtl/duck_round_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/duck_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : duck_round_ctrl
//  Purpose  : Game-flow sequencer for one round of ducks. Sequences spawn,
//             flight, hit pause, fall and escape phases per duck, and owns
//             the shot, hit, duck and score counters.
//  Ports    : Clk, Reset        - system clock, synchronous active-high reset
//             frame_clk         - ~60 Hz frame clock level, edge-detected here
//             start             - starts/restarts a round (IDLE, ROUND_END)
//             trigger, hit      - player fired / crosshair on duck, same Clk
//             fall_done         - duck has reached the ground
//             state             - current state encoding
//             duck_*            - motion/sprite controls (all registered)
//             shots_left, ducks_done, hits, score, round_over - game status
//  Revision : 1.0 - initial release
// ============================================================================
module duck_round_ctrl #(
   parameter int DUCKS_PER_ROUND = 10,
   parameter int SHOTS_PER_DUCK  = 3,
   parameter int FLY_FRAMES      = 600,
   parameter int PAUSE_FRAMES    = 30,
   parameter int FALL_FRAMES     = 120,
   parameter int ESCAPE_FRAMES   = 90,
   parameter int POINTS          = 500
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        start,
   input  logic        trigger,
   input  logic        hit,
   input  logic        fall_done,
   output logic [2:0]  state,
   output logic        duck_respawn,
   output logic        duck_enable,
   output logic        duck_freeze,
   output logic        duck_fall,
   output logic        duck_flyaway,
   output logic [1:0]  shots_left,
   output logic [3:0]  ducks_done,
   output logic [3:0]  hits,
   output logic [15:0] score,
   output logic        round_over
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SPAWN     = 3'd1,
      S_FLYING    = 3'd2,
      S_HIT_PAUSE = 3'd3,
      S_FALLING   = 3'd4,
      S_ESCAPED   = 3'd5,
      S_NEXT      = 3'd6,
      S_ROUND_END = 3'd7
   } state_t;

   // Timeouts fire on the N-th tick, i.e. when the count already holds N-1.
   localparam logic [9:0]  FLY_LAST    = 10'(FLY_FRAMES - 1);
   localparam logic [9:0]  PAUSE_LAST  = 10'(PAUSE_FRAMES - 1);
   localparam logic [9:0]  FALL_LAST   = 10'(FALL_FRAMES - 1);
   localparam logic [9:0]  ESCAPE_LAST = 10'(ESCAPE_FRAMES - 1);
   localparam logic [1:0]  SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
   localparam logic [3:0]  DUCKS_TOTAL = 4'(DUCKS_PER_ROUND);
   localparam logic [16:0] POINTS_EXT  = 17'(POINTS);

   state_t      state_q, state_d;
   logic        frame_clk_q, frame_tick_q;
   logic [9:0]  frame_cnt_q, frame_cnt_d;
   logic [1:0]  shots_q, shots_d;
   logic [3:0]  ducks_q, ducks_d;
   logic [3:0]  hits_q, hits_d;
   logic [15:0] score_q, score_d;
   logic        respawn_q, enable_q, freeze_q, fall_q, flyaway_q, round_over_q;
   logic        respawn_d, enable_d, freeze_d, fall_d, flyaway_d, round_over_d;

   logic        tick_at_last;
   logic        timed_state;
   logic [16:0] score_sum;
   logic [15:0] score_sat;
   logic [3:0]  ducks_inc;

   // Next-state, counters and registered-output decode
   always_comb begin
      state_d      = state_q;
      shots_d      = shots_q;
      ducks_d      = ducks_q;
      hits_d       = hits_q;
      score_d      = score_q;
      frame_cnt_d  = frame_cnt_q;
      tick_at_last = 1'b0;
      timed_state  = 1'b0;
      score_sum    = {1'b0, score_q} + POINTS_EXT;
      score_sat    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      ducks_inc    = ducks_q + 4'd1;

      case (state_q)
         S_FLYING:    tick_at_last = frame_tick_q && (frame_cnt_q == FLY_LAST);
         S_HIT_PAUSE: tick_at_last = frame_tick_q && (frame_cnt_q == PAUSE_LAST);
         S_FALLING:   tick_at_last = frame_tick_q && (frame_cnt_q == FALL_LAST);
         S_ESCAPED:   tick_at_last = frame_tick_q && (frame_cnt_q == ESCAPE_LAST);
         default:     tick_at_last = 1'b0;
      endcase

      case (state_q)
         S_IDLE, S_ROUND_END: begin
            if (start) begin
               state_d = S_SPAWN;
               shots_d = SHOTS_INIT;
               ducks_d = 4'd0;
               hits_d  = 4'd0;
               score_d = 16'd0;
            end
         end
         S_SPAWN: begin
            if (frame_tick_q) state_d = S_FLYING;
         end
         S_FLYING: begin
            // Trigger is evaluated before the flight timeout: a hit wins.
            if (trigger && (shots_q != 2'd0)) begin
               shots_d = shots_q - 2'd1;
               if (hit) begin
                  hits_d  = hits_q + 4'd1;
                  score_d = score_sat;
                  state_d = S_HIT_PAUSE;
               end else if ((shots_q == 2'd1) || tick_at_last) begin
                  state_d = S_ESCAPED;
               end
            end else if (tick_at_last) begin
               state_d = S_ESCAPED;
            end
         end
         S_HIT_PAUSE: begin
            if (tick_at_last) state_d = S_FALLING;
         end
         S_FALLING: begin
            if (fall_done || tick_at_last) state_d = S_NEXT;
         end
         S_ESCAPED: begin
            if (tick_at_last) state_d = S_NEXT;
         end
         S_NEXT: begin
            ducks_d = ducks_inc;
            if (ducks_inc == DUCKS_TOTAL) begin
               state_d = S_ROUND_END;
            end else begin
               state_d = S_SPAWN;
               shots_d = SHOTS_INIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      timed_state = (state_q == S_FLYING) || (state_q == S_HIT_PAUSE) ||
                    (state_q == S_FALLING) || (state_q == S_ESCAPED);

      if (state_d != state_q) begin
         frame_cnt_d = 10'd0;
      end else if (frame_tick_q && timed_state) begin
         frame_cnt_d = frame_cnt_q + 10'd1;
      end

      // Controls are decoded from the next state so they line up with state.
      respawn_d    = (state_d == S_SPAWN) && (state_q != S_SPAWN);
      enable_d     = (state_d == S_SPAWN) || (state_d == S_FLYING) ||
                     (state_d == S_HIT_PAUSE) || (state_d == S_FALLING) ||
                     (state_d == S_ESCAPED);
      freeze_d     = (state_d == S_HIT_PAUSE);
      fall_d       = (state_d == S_FALLING);
      flyaway_d    = (state_d == S_ESCAPED);
      round_over_d = (state_d == S_ROUND_END);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         frame_clk_q  <= 1'b0;
         frame_tick_q <= 1'b0;
         frame_cnt_q  <= 10'd0;
         shots_q      <= 2'd0;
         ducks_q      <= 4'd0;
         hits_q       <= 4'd0;
         score_q      <= 16'd0;
         respawn_q    <= 1'b0;
         enable_q     <= 1'b0;
         freeze_q     <= 1'b0;
         fall_q       <= 1'b0;
         flyaway_q    <= 1'b0;
         round_over_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_clk_q  <= frame_clk;
         frame_tick_q <= frame_clk & ~frame_clk_q;
         frame_cnt_q  <= frame_cnt_d;
         shots_q      <= shots_d;
         ducks_q      <= ducks_d;
         hits_q       <= hits_d;
         score_q      <= score_d;
         respawn_q    <= respawn_d;
         enable_q     <= enable_d;
         freeze_q     <= freeze_d;
         fall_q       <= fall_d;
         flyaway_q    <= flyaway_d;
         round_over_q <= round_over_d;
      end
   end

   assign state        = state_q;
   assign duck_respawn = respawn_q;
   assign duck_enable  = enable_q;
   assign duck_freeze  = freeze_q;
   assign duck_fall    = fall_q;
   assign duck_flyaway = flyaway_q;
   assign shots_left   = shots_q;
   assign ducks_done   = ducks_q;
   assign hits         = hits_q;
   assign score        = score_q;
   assign round_over   = round_over_q;

endmodule
`default_nettype wire
